// File: rtl/iomem_bellek_yanitlayici_pkg.sv
// iomem_bellek_yanitlayici_pkg: shared state encoding, error word, default window base and window test.
package iomem_bellek_yanitlayici_pkg;
  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;
  localparam logic [31:0] HATA_VERISI = 32'hDEAD_BEEF;
  localparam logic [31:0] VARSAYILAN_TABAN = 32'h4000_0000;
  localparam int SERIT_SAYISI = 4;
  function automatic logic pencere_ici(input logic [31:0] adres, input logic [31:0] taban, input int derinlik);
    return ((adres - taban) >> 2) < 32'(derinlik);
  endfunction
endpackage

// File: rtl/iomem_bellek_yanitlayici_bayt_sram.sv
// iomem_bayt_sram: DERINLIK x 32 single-port storage, byte-lane writes and registered reads, never reset.
module iomem_bayt_sram
  import iomem_bellek_yanitlayici_pkg::*;
#(
  parameter int DERINLIK = 1024,
  parameter int AW = $clog2(DERINLIK)
) (
  input  logic                    clk_i,
  input  logic [SERIT_SAYISI-1:0] we_i,
  input  logic                    re_i,
  input  logic [AW-1:0]           adres_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);
  logic [31:0] mem_q [DERINLIK];
  logic [31:0] rdata_q;
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < SERIT_SAYISI; b++)
      if (we_i[b]) mem_q[adres_i][8*b +: 8] <= wdata_i[8*b +: 8];
    if (re_i) rdata_q <= mem_q[adres_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/iomem_bellek_yanitlayici.sv
// iomem_bellek_yanitlayici: iomem slave with GECIKME wait cycles in front of a byte-lane SRAM.
// Defining IOMEM_ADRES_HATA_EN turns out-of-window accesses into errors instead of wrapping.
module iomem_bellek_yanitlayici
  import iomem_bellek_yanitlayici_pkg::*;
#(
  parameter int          DERINLIK    = 1024,
  parameter int          GECIKME     = 2,
  parameter logic [31:0] TABAN_ADRES = VARSAYILAN_TABAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iomem_valid_i,
  input  logic [3:0]  iomem_wstrb_i,
  input  logic [31:0] iomem_addr_i,
  input  logic [31:0] iomem_wdata_i,
  output logic        iomem_ready_o,
  output logic [31:0] iomem_rdata_o,
  output logic        mesgul_o,
  output logic        hata_o
);
  localparam int AW = $clog2(DERINLIK);
`ifdef IOMEM_ADRES_HATA_EN
  localparam bit HATA_EN = 1'b1;
`else
  localparam bit HATA_EN = 1'b0;
`endif
  durum_t durum_q, durum_d;
  logic [3:0] sayac_q, sayac_d, wstrb_q, wstrb_s, sram_we;
  logic [31:0] adres_q, wdata_q, adres_s, wdata_s, sram_rdata;
  logic [AW-1:0] kelime_s;
  logic gir_yanit, sram_re, hata_s;
  // In BOSTA the request on the bus is used directly so GECIKME=0 can hit the SRAM on the accepting edge.
  assign adres_s = (durum_q == BOSTA) ? iomem_addr_i : adres_q;
  assign wdata_s = (durum_q == BOSTA) ? iomem_wdata_i : wdata_q;
  assign wstrb_s = (durum_q == BOSTA) ? iomem_wstrb_i : wstrb_q;
  assign kelime_s = AW'((adres_s - TABAN_ADRES) >> 2);
  assign hata_s = HATA_EN && !pencere_ici(adres_s, TABAN_ADRES, DERINLIK);
  assign gir_yanit = rst_i && durum_d == YANIT && durum_q != YANIT;
  assign sram_we = (gir_yanit && !hata_s) ? wstrb_s : 4'b0;
  assign sram_re = gir_yanit && !hata_s && wstrb_s == 4'b0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      durum_q <= BOSTA;
      sayac_q <= '0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      adres_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (durum_q == BOSTA && iomem_valid_i) begin
      adres_q <= iomem_addr_i;
      wdata_q <= iomem_wdata_i;
      wstrb_q <= iomem_wstrb_i;
    end
  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    case (durum_q)
      BOSTA: if (iomem_valid_i) begin
        durum_d = (GECIKME == 0) ? YANIT : BEKLE;
        sayac_d = 4'(GECIKME);
      end
      BEKLE: begin
        sayac_d = sayac_q - 4'd1;
        durum_d = (sayac_q == 4'd1) ? YANIT : BEKLE;
      end
      default: durum_d = BOSTA;
    endcase
  end
  // Busy also covers the accepting cycle so back-to-back requests never show a gap.
  always_comb begin
    iomem_ready_o = durum_q == YANIT;
    hata_o = iomem_ready_o && HATA_EN && !pencere_ici(adres_q, TABAN_ADRES, DERINLIK);
    mesgul_o = rst_i && (durum_q != BOSTA || iomem_valid_i);
    iomem_rdata_o = (!iomem_ready_o || wstrb_q != 4'b0) ? 32'h0 : hata_o ? HATA_VERISI : sram_rdata;
  end
  iomem_bayt_sram #(.DERINLIK(DERINLIK)) u_sram (
    .clk_i(clk_i),
    .we_i(sram_we),
    .re_i(sram_re),
    .adres_i(kelime_s),
    .wdata_i(wdata_s),
    .rdata_o(sram_rdata)
  );
endmodule

// File: doc/iomem_bellek_yanitlayici.md
IOMEM_BELLEK_YANITLAYICI -- requirements
Module: iomem_bellek_yanitlayici

Interface
REQ-001 The block SHALL have parameter DERINLIK, default 1024, memory depth in 32-bit words, power of two.
REQ-002 The block SHALL have parameter GECIKME, default 2, wait cycles inserted before iomem_ready_o, range 0..15.
REQ-003 The block SHALL have parameter TABAN_ADRES, default 32'h4000_0000, byte base address of the memory window.
REQ-004 The block SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 The block SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port iomem_valid_i  input  1  request valid from the initiator.
REQ-007 The block SHALL have port iomem_wstrb_i  input  4  byte write strobes; 4'b0000 means read.
REQ-008 The block SHALL have port iomem_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 The block SHALL have port iomem_wdata_i  input  32  write data.
REQ-010 The block SHALL have port iomem_ready_o  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port iomem_rdata_o  output  32  read data, valid while iomem_ready_o=1.
REQ-012 The block SHALL have port mesgul_o  output  1  high from request acceptance through the ready cycle.
REQ-013 The block SHALL have port hata_o  output  1  one-cycle pulse, coincident with ready, on an out-of-window access.

Function
REQ-014 The block SHALL implement states BOSTA, BEKLE, YANIT.
REQ-015 In BOSTA, iomem_valid_i=1 at a rising edge SHALL latch addr/wstrb/wdata, load the counter with GECIKME, and go to BEKLE, or to YANIT if GECIKME=0.
REQ-016 In BEKLE, the counter SHALL decrement once per cycle, and the block SHALL go to YANIT on the edge where the counter equals 1.
REQ-017 iomem_ready_o SHALL be high only in YANIT; total latency from the accepting edge to ready high SHALL be GECIKME+1 cycles.
REQ-018 Writes SHALL update only the byte lanes with a set strobe, committed on the edge entering YANIT.
REQ-019 On reads, iomem_rdata_o SHALL be registered on the edge entering YANIT; on writes, it SHALL be 32'h0.
REQ-020 Once accepted, a request SHALL ignore input changes, including valid dropping early, until completion.
REQ-021 YANIT SHALL always return to BOSTA after one cycle; a valid still high in YANIT SHALL NOT be accepted, and the next request SHALL be accepted at the earliest on the following edge.
REQ-022 Word index SHALL be computed as (addr - TABAN_ADRES) >> 2.
REQ-023 Outside YANIT, iomem_rdata_o SHALL hold 32'h0.

Reset
REQ-024 On reset assertion, the block SHALL immediately force BOSTA, ready=0, rdata=0, mesgul_o=0, hata_o=0, and counter=0, aborting any in-flight request with no memory write.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With IOMEM_ADRES_HATA_EN defined, an address outside [TABAN_ADRES, TABAN_ADRES+4*DERINLIK) SHALL complete with normal latency, drop writes, return 32'hDEAD_BEEF on reads, and pulse hata_o.
REQ-027 Without IOMEM_ADRES_HATA_EN, the word index SHALL wrap modulo DERINLIK, every access SHALL hit memory, and hata_o SHALL be tied to 0.

Structure
REQ-028 The shared package SHALL hold the state encoding (BOSTA/BEKLE/YANIT), the 32'hDEAD_BEEF error constant, and the default TABAN_ADRES.
REQ-029 Storage SHALL be the sub-module iomem_bayt_sram: DERINLIK x 32 bits, 4 byte-enable lanes, synchronous read and write; the FSM and counter SHALL remain in the top.

Verification
REQ-030 With GECIKME=2, write 32'hA5A5_1234 to 32'h4000_0010 with wstrb=4'hF, then read it back -> ready rises 3 cycles after each accepting edge and rdata=32'hA5A5_1234.
REQ-031 With word 32'h4000_0020 holding 32'h1122_3344, write wdata=32'hFFFF_FFFF with wstrb=4'b0101 -> a readback returns 32'h11FF_33FF.
REQ-032 With GECIKME=0, hold valid high continuously over two reads -> ready pulses on alternate cycles, and mesgul_o is never low between the two requests.
REQ-033 Drop valid one cycle after acceptance of a read -> the read still completes and ready pulses once.
REQ-034 Assert rst_i low in BEKLE during a write to 32'h4000_0030 -> ready never pulses and a post-reset readback returns the old value.
REQ-035 With IOMEM_ADRES_HATA_EN, read 32'h5000_0000 -> rdata=32'hDEAD_BEEF and hata_o=1 for one cycle; without the macro, with DERINLIK=1024, 32'h4000_1000 aliases to 32'h4000_0000.
